// File: rtl/nios_mult_seq.sv
`default_nettype none
// ============================================================================
// nios_mult_seq : iterative multiplier, one SLICE x SLICE partial product per
//                 cycle into a 2*WIDTH accumulator; MUL/MULH/MULHSU/MULHU.
// Revision      : 1.0
// ============================================================================
module nios_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [2*WIDTH-1:0] out_full
);

  localparam int unsigned K   = WIDTH / SLICE;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned PPW = 2 * SLICE;
  localparam int unsigned JW  = (K > 1) ? $clog2(K) : 1;
  localparam logic [JW-1:0] LAST = JW'(K - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_mag_q;
  logic [WIDTH-1:0]  b_mag_q;
  logic              neg_q;
  logic [1:0]        op_q;
  logic [JW-1:0]     j_q;
  logic [JW-1:0]     k_q;
  logic [PW-1:0]     acc_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              sign_a_d;
  logic              sign_b_d;
  logic [WIDTH-1:0]  a_mag_d;
  logic [WIDTH-1:0]  b_mag_d;
  logic [SLICE-1:0]  a_sl_d;
  logic [SLICE-1:0]  b_sl_d;
  logic [PPW-1:0]    pp_d;
  logic [31:0]       shamt_d;
  logic [PW-1:0]     acc_d;

  // Magnitudes are kept unsigned so |most-negative| needs no extra bit.
  always_comb begin
    sign_a_d = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[WIDTH-1];
    sign_b_d = (in_op == OP_MULH) && in_b[WIDTH-1];
    a_mag_d  = sign_a_d ? -in_a : in_a;
    b_mag_d  = sign_b_d ? -in_b : in_b;

    a_sl_d = '0;
    b_sl_d = '0;
    for (int s = 0; s < int'(K); s++) begin
      if (j_q == JW'(s)) a_sl_d = a_mag_q[s*SLICE +: SLICE];
      if (k_q == JW'(s)) b_sl_d = b_mag_q[s*SLICE +: SLICE];
    end

    pp_d    = PPW'(a_sl_d) * PPW'(b_sl_d);
    shamt_d = SLICE * (32'(j_q) + 32'(k_q));
    acc_d   = acc_q + (PW'(pp_d) << shamt_d);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_full   = acc_q;
  assign out_result = (op_q == OP_MUL) ? acc_q[WIDTH-1:0] : acc_q[PW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      neg_q       <= 1'b0;
      op_q        <= 2'b00;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            neg_q      <= sign_a_d ^ sign_b_d;
            op_q       <= in_op;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          if (j_q == LAST) begin
            j_q <= '0;
            if (k_q == LAST) begin
              k_q     <= '0;
              state_q <= S_SIGN;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        S_SIGN: begin
          acc_q       <= neg_q ? -acc_q : acc_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          // in_ready returns one cycle after the result handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
